// File: rtl/fifo_dot_pkg.sv
// Shared types and constants for the FIFO dot-product accumulator.
// Lane geometry is fixed here; accumulator and count widths are parameters of
// the top module, so one package serves every build.
package fifo_dot_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned PROD_W = 2 * LANE_W;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } t_dot_state;

    // Signed lane idx of a packed word; lane i lives in bits [LANE_W*i +: LANE_W].
    function automatic logic signed [LANE_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                              input int unsigned idx);
        return word[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/fifo_dot_accum_if.sv
// Job-control, FIFO and result signals of the dot-product accumulator.
//   master: wgt_load, wgt_data, start, len, in_valid, in_data -> block
//   slave : in_ready, busy, result_valid, result -> consumer / MMIO read path
interface fifo_dot_accum_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
);
    import fifo_dot_pkg::*;

    logic              wgt_load;
    logic [WORD_W-1:0] wgt_data;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              result_valid;
    logic [ACC_W-1:0]  result;

    modport master (
        output wgt_load, wgt_data, start, len, in_valid, in_data,
        input  in_ready, busy, result_valid, result
    );

    modport slave (
        input  wgt_load, wgt_data, start, len, in_valid, in_data,
        output in_ready, busy, result_valid, result
    );

endinterface

// File: rtl/fifo_dot_accum_lane_tree.sv
// Two-stage lane-wise signed multiply and reduction.
//   clk, rst      : clock and synchronous active-high reset
//   valid_i       : word on data_i is accepted this edge
//   data_i, wgt_i : packed signed lanes
//   mul_valid_o   : products stage holds a word
//   sum_valid_o   : sum_o holds a reduced word
//   sum_o         : signed sum of the lane products
module dot_lane_tree
    import fifo_dot_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [WORD_W-1:0]       data_i,
    input  logic [WORD_W-1:0]       wgt_i,
    output logic                    mul_valid_o,
    output logic                    sum_valid_o,
    output logic signed [SUM_W-1:0] sum_o
);

    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     mul_valid_q;
    logic                     sum_valid_q;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[i] = PROD_W'(lane_extract(data_i, i)) * PROD_W'(lane_extract(wgt_i, i));
        end
    end

    // Written as a chain; synthesis rebalances it into a tree.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_valid_q <= 1'b0;
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            mul_valid_q <= valid_i;
            sum_valid_q <= mul_valid_q;
            sum_q       <= sum_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign mul_valid_o = mul_valid_q;
    assign sum_valid_o = sum_valid_q;
    assign sum_o       = sum_q;

endmodule

// File: rtl/fifo_dot_accum.sv
// Consumes 64-bit FIFO words, multiplies each signed lane against a weight
// register, and accumulates the lane sums over a programmed number of words.
//   clk, rst : clock and synchronous active-high reset
//   bus_io   : slave side of fifo_dot_accum_if (job control, FIFO word in,
//              in_ready/busy status, result with one-cycle result_valid)
module fifo_dot_accum
    import fifo_dot_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    fifo_dot_accum_if.slave  bus_io
);

    t_dot_state        state_q, state_d;
    logic [WORD_W-1:0] wgt_q, wgt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              res_valid_q, res_valid_d;

    logic                    in_ready;
    logic                    accept;
    logic                    mul_valid;
    logic                    sum_valid;
    logic signed [SUM_W-1:0] tree_sum;
    logic signed [ACC_W-1:0] sum_ext;

    // in_ready depends on state only, so there is no path from in_valid.
    assign in_ready = (state_q == RUN);
    assign accept   = bus_io.in_valid && in_ready;

    dot_lane_tree u_tree (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (accept),
        .data_i      (bus_io.in_data),
        .wgt_i       (wgt_q),
        .mul_valid_o (mul_valid),
        .sum_valid_o (sum_valid),
        .sum_o       (tree_sum)
    );

    // Sign-extends (or wraps, for narrow builds) the tree sum to ACC_W.
    assign sum_ext = ACC_W'(tree_sum);

    always_comb begin
        state_d     = state_q;
        wgt_d       = wgt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        rem_d       = rem_q;
        res_valid_d = 1'b0;

        if (sum_valid) begin
            acc_d = acc_q + sum_ext;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (bus_io.wgt_load) begin
                    wgt_d = bus_io.wgt_data;
                end
                if (bus_io.start) begin
                    acc_d   = '0;
                    rem_d   = bus_io.len;
                    state_d = (bus_io.len != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (accept) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last word has left both pipeline stages once both valids are clear.
                if (!mul_valid && !sum_valid) begin
                    result_d    = acc_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wgt_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            rem_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wgt_q       <= wgt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            rem_q       <= rem_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus_io.in_ready     = in_ready;
    assign bus_io.busy         = (state_q == RUN) || (state_q == DRAIN);
    assign bus_io.result_valid = res_valid_q;
    assign bus_io.result       = result_q;

endmodule

// File: tb/tb_fifo_dot_accum.sv
// Drives a 32-bit and a 16-bit accumulator build with identical stimulus and
// checks both against a plain-arithmetic dot-product model via scoreboards.
module tb_fifo_dot_accum;

    logic        clk;
    logic        rst;
    logic        wgt_load;
    logic [63:0] wgt_data;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [63:0] in_data;

    int n_tests;
    int n_fail;

    logic [31:0] exp32_q[$];
    logic [15:0] exp16_q[$];
    logic [63:0] words[$];
    bit          vpat[$];
    logic [63:0] w_model;

    fifo_dot_accum_if #(.ACC_W(32), .CNT_W(8)) if32 ();
    fifo_dot_accum_if #(.ACC_W(16), .CNT_W(8)) if16 ();

    assign if32.wgt_load = wgt_load;
    assign if32.wgt_data = wgt_data;
    assign if32.start    = start;
    assign if32.len      = len;
    assign if32.in_valid = in_valid;
    assign if32.in_data  = in_data;
    assign if16.wgt_load = wgt_load;
    assign if16.wgt_data = wgt_data;
    assign if16.start    = start;
    assign if16.len      = len;
    assign if16.in_valid = in_valid;
    assign if16.in_data  = in_data;

    fifo_dot_accum #(.ACC_W(32), .CNT_W(8)) u_dut32 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if32.slave)
    );

    fifo_dot_accum #(.ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint dot(input logic [63:0] d, input logic [63:0] w);
        longint s = 0;
        for (int i = 0; i < 8; i++) begin
            logic signed [7:0] a;
            logic signed [7:0] b;
            a = d[8*i +: 8];
            b = w[8*i +: 8];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    // Scoreboard monitors: pop one expectation per result pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (if32.result_valid === 1'b1) begin
                if (exp32_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result32: got 0x%0h, expected no result", if32.result);
                end else begin
                    chk("result32", if32.result, exp32_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (if16.result_valid === 1'b1) begin
                if (exp16_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result16: got 0x%0h, expected no result", if16.result);
                end else begin
                    chk("result16", if16.result, exp16_q.pop_front());
                end
            end
        end
    end

    // Called at a negedge with the block in IDLE/DONE. Words come from `words`
    // (random fill), valid pattern from `vpat` (then random with bub% bubbles).
    task automatic run_job(input int unsigned n, input bit ld, input logic [63:0] w,
                           input int unsigned bub, input bit poke);
        longint      total = 0;
        int unsigned idx = 0;
        int unsigned cyc = 0;
        int unsigned k;
        bit          acc_now;
        wgt_load = ld;
        wgt_data = w;
        start    = 1'b1;
        len      = 8'(n);
        if (ld) w_model = w;
        while (words.size() < n) words.push_back({$urandom, $urandom});
        @(negedge clk);
        wgt_load = 1'b0;
        start    = 1'b0;
        chk("busy_start", if32.busy, 1);
        while (idx < n) begin
            if (cyc >= 1000) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: got %0d words, expected %0d", idx, n);
                break;
            end
            if (vpat.size() != 0) in_valid = vpat.pop_front();
            else                  in_valid = ($urandom_range(99) >= bub);
            in_data = words[idx];
            if (poke && cyc == 1) begin
                wgt_load = 1'b1;
                wgt_data = '0;
                start    = 1'b1;
                len      = 8'd7;
            end
            chk("in_ready_run", if32.in_ready, 1);
            acc_now = in_valid && if32.in_ready;
            @(negedge clk);
            wgt_load = 1'b0;
            start    = 1'b0;
            if (acc_now) begin
                total += dot(words[idx], w_model);
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        words.delete();
        vpat.delete();
        exp32_q.push_back(total[31:0]);
        exp16_q.push_back(total[15:0]);
        chk("in_ready_drain", if32.in_ready, 0);
        k = 1;
        while (if32.result_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, (n == 0) ? 2 : 4);
        @(negedge clk);
        chk("pulse_end", if32.result_valid, 0);
        chk("busy_done", if32.busy, 0);
        chk("result_hold32", if32.result, total[31:0]);
        chk("result_hold16", if16.result, total[15:0]);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wgt_load = 1'b0;
        wgt_data = '0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        w_model  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", if32.in_ready, 0);
        chk("rst_busy", if32.busy, 0);
        chk("rst_result_valid", if32.result_valid, 0);
        chk("rst_result32", if32.result, 0);
        chk("rst_result16", if16.result, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single word, unit weights.
        words.push_back(64'h0102030405060708);
        vpat.push_back(1'b1);
        run_job(1, 1'b1, 64'h0101010101010101, 0, 1'b0);

        // Negative lanes.
        words.push_back(64'h7F7F7F7F7F7F7F7F);
        words.push_back(64'h7F7F7F7F7F7F7F7F);
        run_job(2, 1'b1, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0);

        // Bubbles and stall.
        repeat (3) words.push_back(64'h0101010101010101);
        vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0);
        vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b1);
        run_job(3, 1'b1, 64'h0202020202020202, 0, 1'b0);

        // Empty job, then start/wgt_load while busy must be ignored.
        run_job(0, 1'b0, '0, 0, 1'b0);
        run_job(2, 1'b0, '0, 0, 1'b1);

        // Wraps to zero in the 16-bit build.
        repeat (5) words.push_back(64'h8080808080808080);
        run_job(5, 1'b1, 64'h8080808080808080, 0, 1'b0);

        for (int j = 0; j < 25; j++) begin
            int unsigned n;
            n = $urandom_range(12);
            run_job(n, ($urandom_range(3) != 0), {$urandom, $urandom}, $urandom_range(60),
                    (n > 1) && ($urandom_range(1) == 1));
        end

        // Leaves a nonzero result so the reset clear is observable.
        words.push_back(64'h0101010101010101);
        run_job(1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0);

        // Reset after 2 of 4 words.
        wgt_load = 1'b1;
        wgt_data = {$urandom, $urandom} | 64'h0101010101010101;
        start    = 1'b1;
        len      = 8'd4;
        @(negedge clk);
        wgt_load = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        w_model  = '0;
        chk("midrst_in_ready", if32.in_ready, 0);
        chk("midrst_busy", if32.busy, 0);
        chk("midrst_result_valid", if32.result_valid, 0);
        chk("midrst_result32", if32.result, 0);
        chk("midrst_result16", if16.result, 0);
        // Weights were cleared, so this job must produce zero.
        words.push_back(64'h0102030405060708);
        run_job(1, 1'b0, '0, 0, 1'b0);
        run_job(4, 1'b1, {$urandom, $urandom}, 20, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty32", exp32_q.size(), 0);
        chk("sb_empty16", exp16_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
